// File: rtl/fft8_stream.sv
// fft8_stream: 8-point real-input FFT, valid/ready in and out, one shared multiplier.
// Build option FFT8_SCALE_EN: every output word is divided by 8 (floor) in COMB.
module fft8_stream #(
    parameter int W       = 16,
    parameter int FRAC    = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*W-1:0]      in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*(W+4)-1:0]  out_re,
    output logic [8*(W+4)-1:0]  out_im
);

    localparam int WI    = W + 4;
    localparam int WP    = 2 * WI;
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam int C     = $rtoi(0.70710678 * real'(1 << FRAC) + 0.5);

    localparam logic signed [WI-1:0] POS_C = WI'(C);
    localparam logic signed [WI-1:0] NEG_C = -POS_C;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MUL_A = 3'd1;
    localparam logic [2:0] MUL_B = 3'd2;
    localparam logic [2:0] COMB  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    logic signed [WI-1:0] xs [8];
    logic signed [WI-1:0] t1, t2, t3, t5;
    logic signed [WI-1:0] m3, m6, t4, t6;
    logic signed [WI-1:0] m4, m7;
    logic signed [WI-1:0] mul_a, mul_b;
    logic signed [WP-1:0] pipe [MUL_LAT];
    logic signed [WI-1:0] re_b [8];
    logic signed [WI-1:0] im_b [8];

    function automatic logic signed [WI-1:0] scale(
        input logic signed [WI-1:0] v
    );
`ifdef FFT8_SCALE_EN
        return v >>> 3;
`else
        return v;
`endif
    endfunction

    assign in_ready = (state == IDLE) && !rst;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            xs[n] = {{4{in_data[n*W+W-1]}}, in_data[n*W +: W]};
        end
    end

    // Operands are held for the whole phase; the pipe tail is sampled
    // exactly MUL_LAT cycles after the phase's first cycle.
    always_comb begin
        if (state == MUL_B) begin
            mul_a = t4 + t6;
            mul_b = NEG_C;
        end else begin
            mul_a = t4 - t6;
            mul_b = POS_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= WP'(mul_a) * WP'(mul_b);
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        re_b[0] = t1 + t2 + t3 + t5;
        im_b[0] = '0;
        re_b[4] = t1 + t2 - t3 - t5;
        im_b[4] = '0;
        re_b[2] = t1 - t2;
        im_b[2] = t5 - t3;
        re_b[6] = re_b[2];
        im_b[6] = -im_b[2];
        re_b[1] = m3 + m4;
        im_b[1] = m6 + m7;
        re_b[7] = re_b[1];
        im_b[7] = -im_b[1];
        re_b[5] = m3 - m4;
        im_b[5] = m6 - m7;
        re_b[3] = re_b[5];
        im_b[3] = -im_b[5];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            t1 <= '0; t2 <= '0; t3 <= '0; t5 <= '0;
            m3 <= '0; m6 <= '0; t4 <= '0; t6 <= '0;
            m4 <= '0; m7 <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        t1    <= xs[0] + xs[4];
                        t2    <= xs[6] + xs[2];
                        t3    <= xs[1] + xs[5];
                        t5    <= xs[3] + xs[7];
                        m3    <= xs[0] - xs[4];
                        m6    <= xs[6] - xs[2];
                        t4    <= xs[1] - xs[5];
                        t6    <= xs[3] - xs[7];
                        cnt   <= '0;
                        state <= MUL_A;
                    end
                end
                MUL_A: begin
                    if (cnt == CNT_W'(MUL_LAT - 1)) begin
                        cnt   <= '0;
                        state <= MUL_B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MUL_B: begin
                    if (cnt == '0) begin
                        m4 <= WI'(pipe[MUL_LAT-1] >>> FRAC);
                    end
                    if (cnt == CNT_W'(MUL_LAT)) begin
                        m7    <= WI'(pipe[MUL_LAT-1] >>> FRAC);
                        cnt   <= '0;
                        state <= COMB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMB: begin
                    for (int k = 0; k < 8; k++) begin
                        out_re[k*WI +: WI] <= scale(re_b[k]);
                        out_im[k*WI +: WI] <= scale(im_b[k]);
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
